sdram_cmd_fsm: RTL and testbench

//  Init + work command FSM of the SDRAM controller. Consumes done_200us / end_* / ref_req from sdram_t.

---
 rtl/sdram_cmd_fsm_pkg.sv | 20 ++
 rtl/sdram_cmd_fsm_if.sv | 19 +
 rtl/sdram_cmd_fsm.sv | 118 +++++++++++
 tb/tb_sdram_cmd_fsm.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sdram_cmd_fsm_pkg.sv
// sdram_cmd_fsm_pkg: state codes, SDRAM command encodings and timing constants
package sdram_cmd_fsm_pkg;
  typedef enum logic [4:0] {
    I_POWON, I_PRE, I_PRE_TRP, I_AR0, I_AR0_TRFC,
    I_AR1, I_AR1_TRFC, I_MRS, I_MRS_TMRD, I_DONE
  } init_t;
  typedef enum logic [4:0] {
    S_IDLE, S_AR, S_TRFC, S_ACT, S_TRCD, S_WR,
    S_WR_DATA, S_TDAL, S_RD, S_CL, S_RD_DATA, S_RWAIT
  } work_t;
  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam int TRP = 2, TRFC = 7, TMRD = 2, TRCD = 2, TCL = 3, TDAL = 3, R_BL = 8, W_BL = 8;
endpackage

// File: rtl/sdram_cmd_fsm_if.sv
// sdram_cmd_fsm_if: user request/ack port plus the SDRAM command bus
interface sdram_cmd_fsm_if #(parameter int ROW_W = 12, COL_W = 9, BA_W = 2);
  localparam int AW = BA_W + ROW_W + COL_W;
  logic sdram_ref_req, sdram_ref_ack, sdram_wr_req, sdram_wr_ack, sdram_rd_req, sdram_rd_ack;
  logic [AW-1:0] wr_addr, rd_addr;
  logic sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [BA_W-1:0] sdram_ba;
  logic [ROW_W-1:0] sdram_addr;
  modport master (
    output sdram_ref_req, sdram_wr_req, sdram_rd_req, wr_addr, rd_addr,
    input sdram_ref_ack, sdram_wr_ack, sdram_rd_ack,
    input sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr
  );
  modport slave (
    input sdram_ref_req, sdram_wr_req, sdram_rd_req, wr_addr, rd_addr,
    output sdram_ref_ack, sdram_wr_ack, sdram_rd_ack,
    output sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr
  );
endinterface

// File: rtl/sdram_cmd_fsm.sv
// sdram_cmd_fsm: SDRAM power-up init sequence and refresh/write/read command arbitration
module sdram_cmd_fsm
  import sdram_cmd_fsm_pkg::*;
#(
  parameter int ROW_W = 12,
  parameter int COL_W = 9,
  parameter int BA_W = 2,
  parameter logic [ROW_W-1:0] MR_VAL = 'h033
) (
  input  logic clk,
  input  logic rst,
  input  logic done_200us,
  input  logic end_trp, end_trfc, end_tmrd, end_trcd, end_tcl,
  input  logic end_tread, end_twait, end_twrite, end_tdal,
  input  logic ref_domain,
  sdram_cmd_fsm_if.slave bus,
  output logic [4:0] init_state,
  output logic [4:0] work_state,
  output logic [4:0] cur_init_state,
  output logic [4:0] cur_work_state
);
  localparam logic [ROW_W-1:0] A10 = ROW_W'(1024);
  init_t init_q;
  work_t work_q;
  logic [3:0] cmd;
  logic [BA_W-1:0] ba_q, bank_q;
  logic [ROW_W-1:0] addr_q;
  logic [COL_W-1:0] col_q;
  logic wr_op;
  logic [BA_W+ROW_W+COL_W-1:0] req_addr;
  // column zero-extended onto the row bus with auto-precharge (A10) forced
  function automatic logic [ROW_W-1:0] col_addr(input logic [COL_W-1:0] c);
    col_addr = ROW_W'(c) | A10;
  endfunction
  assign req_addr = bus.sdram_wr_req ? bus.wr_addr : bus.rd_addr;
  assign init_state = init_q;
  assign work_state = work_q;
  assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = cmd;
  assign bus.sdram_ba = ba_q;
  assign bus.sdram_addr = addr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      init_q <= I_POWON;
      work_q <= S_IDLE;
      cur_init_state <= I_POWON;
      cur_work_state <= S_IDLE;
      cmd <= CMD_NOP;
      ba_q <= '0;
      addr_q <= '0;
      bank_q <= '0;
      col_q <= '0;
      wr_op <= 1'b0;
      bus.sdram_ref_ack <= 1'b0;
      bus.sdram_wr_ack <= 1'b0;
      bus.sdram_rd_ack <= 1'b0;
    end else begin
      cmd <= CMD_NOP;
      ba_q <= '0;
      addr_q <= '0;
      bus.sdram_ref_ack <= 1'b0;
      bus.sdram_wr_ack <= 1'b0;
      bus.sdram_rd_ack <= 1'b0;
      cur_init_state <= init_q;
      cur_work_state <= work_q;
      case (init_q)
        I_POWON: if (done_200us) begin init_q <= I_PRE; cmd <= CMD_PRE; addr_q <= A10; end
        I_PRE: init_q <= I_PRE_TRP;
        I_PRE_TRP: if (end_trp) begin init_q <= I_AR0; cmd <= CMD_AREF; end
        I_AR0: init_q <= I_AR0_TRFC;
        I_AR0_TRFC: if (end_trfc) begin init_q <= I_AR1; cmd <= CMD_AREF; end
        I_AR1: init_q <= I_AR1_TRFC;
        I_AR1_TRFC: if (end_trfc) begin init_q <= I_MRS; cmd <= CMD_MRS; addr_q <= MR_VAL; end
        I_MRS: init_q <= I_MRS_TMRD;
        I_MRS_TMRD: if (end_tmrd) init_q <= I_DONE;
        I_DONE: ;
        default: init_q <= I_POWON;
      endcase
      if (init_q == I_DONE) begin
        case (work_q)
          S_IDLE:
            if (bus.sdram_ref_req) begin
              work_q <= S_AR;
              cmd <= CMD_AREF;
              bus.sdram_ref_ack <= 1'b1;
            end else if (!ref_domain && (bus.sdram_wr_req || bus.sdram_rd_req)) begin
              work_q <= S_ACT;
              cmd <= CMD_ACT;
              wr_op <= bus.sdram_wr_req;
              bank_q <= req_addr[BA_W+ROW_W+COL_W-1 -: BA_W];
              col_q <= req_addr[COL_W-1:0];
              ba_q <= req_addr[BA_W+ROW_W+COL_W-1 -: BA_W];
              addr_q <= req_addr[COL_W +: ROW_W];
              bus.sdram_wr_ack <= bus.sdram_wr_req;
              bus.sdram_rd_ack <= !bus.sdram_wr_req;
            end
          S_AR: work_q <= S_TRFC;
          S_TRFC: if (end_trfc) work_q <= S_IDLE;
          S_ACT: work_q <= S_TRCD;
          S_TRCD:
            if (end_trcd) begin
              work_q <= wr_op ? S_WR : S_RD;
              cmd <= wr_op ? CMD_WR : CMD_RD;
              ba_q <= bank_q;
              addr_q <= col_addr(col_q);
            end
          S_WR: work_q <= S_WR_DATA;
          S_WR_DATA: if (end_twrite) work_q <= S_TDAL;
          S_TDAL: if (end_tdal) work_q <= S_IDLE;
          S_RD: work_q <= S_CL;
          S_CL: if (end_tcl) work_q <= S_RD_DATA;
          S_RD_DATA: if (end_tread) work_q <= S_RWAIT;
          S_RWAIT: if (end_twait) work_q <= S_IDLE;
          default: work_q <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sdram_cmd_fsm.sv
// tb_sdram_cmd_fsm: directed + randomized checks of init, refresh, write, read, blocking and reset
module tb_sdram_cmd_fsm;
  import sdram_cmd_fsm_pkg::*;
  localparam int E_TRP = 0, E_TRFC = 1, E_TMRD = 2, E_TRCD = 3, E_TCL = 4;
  localparam int E_TREAD = 5, E_TWAIT = 6, E_TWRITE = 7, E_TDAL = 8;
  logic clk = 1'b0, rst = 1'b1, done_200us = 1'b0, ref_domain = 1'b0;
  logic [8:0] ends = '0;
  logic [4:0] init_state, work_state, cur_init_state, cur_work_state;
  logic [4:0] pi = I_POWON, pw = S_IDLE;
  int checks = 0, errors = 0;
  sdram_cmd_fsm_if bus ();
  sdram_cmd_fsm dut (
    .clk(clk), .rst(rst), .done_200us(done_200us),
    .end_trp(ends[E_TRP]), .end_trfc(ends[E_TRFC]), .end_tmrd(ends[E_TMRD]),
    .end_trcd(ends[E_TRCD]), .end_tcl(ends[E_TCL]), .end_tread(ends[E_TREAD]),
    .end_twait(ends[E_TWAIT]), .end_twrite(ends[E_TWRITE]), .end_tdal(ends[E_TDAL]),
    .ref_domain(ref_domain), .bus(bus),
    .init_state(init_state), .work_state(work_state),
    .cur_init_state(cur_init_state), .cur_work_state(cur_work_state)
  );
  always #5 clk = ~clk;
  // READ/WRITE carry the column on the row bus with the auto-precharge bit (1024) added
  function automatic logic [11:0] col_cmd_addr(input logic [8:0] c);
    return 12'h400 + 12'(c);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
  endtask
  task automatic see(input string tag, input logic [4:0] is, input logic [4:0] ws,
                     input logic [3:0] c, input logic [1:0] b, input logic [11:0] a,
                     input logic [2:0] ack);
    chk({tag, " state"}, 32'({init_state, work_state}), 32'({is, ws}));
    chk({tag, " cur"}, 32'({cur_init_state, cur_work_state}), 32'({pi, pw}));
    chk({tag, " cmd"}, 32'({bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
                            bus.sdram_ba, bus.sdram_addr}), 32'({c, b, a}));
    chk({tag, " ack"}, 32'({bus.sdram_ref_ack, bus.sdram_wr_ack, bus.sdram_rd_ack}), 32'(ack));
    pi = is;
    pw = ws;
  endtask
  // idle a few cycles pulsing unrelated end_* flags, then pulse the awaited one
  task automatic wait_end(input string tag, input int e, input logic [4:0] is, input logic [4:0] ws);
    int d = int'($urandom_range(0, 3));
    for (int i = 0; i < d; i++) begin
      ends = 9'(1) << ((e + 1 + int'($urandom_range(0, 7))) % 9);
      step;
      ends = '0;
      see({tag, " hold"}, is, ws, CMD_NOP, 2'd0, 12'd0, 3'd0);
    end
    ends = 9'(1) << e;
    step;
    ends = '0;
  endtask
  task automatic init_seq;
    int d = int'($urandom_range(1, 4));
    for (int i = 0; i < d; i++) begin
      step;
      see("powon", I_POWON, S_IDLE, CMD_NOP, 2'd0, 12'd0, 3'd0);
    end
    done_200us = 1'b1;
    step;
    done_200us = 1'b0;
    see("pre", I_PRE, S_IDLE, CMD_PRE, 2'd0, 12'h400, 3'd0);
    step;
    see("pre_trp", I_PRE_TRP, S_IDLE, CMD_NOP, 2'd0, 12'd0, 3'd0);
    wait_end("trp", E_TRP, I_PRE_TRP, S_IDLE);
    see("ar0", I_AR0, S_IDLE, CMD_AREF, 2'd0, 12'd0, 3'd0);
    step;
    see("ar0_trfc", I_AR0_TRFC, S_IDLE, CMD_NOP, 2'd0, 12'd0, 3'd0);
    wait_end("trfc0", E_TRFC, I_AR0_TRFC, S_IDLE);
    see("ar1", I_AR1, S_IDLE, CMD_AREF, 2'd0, 12'd0, 3'd0);
    step;
    see("ar1_trfc", I_AR1_TRFC, S_IDLE, CMD_NOP, 2'd0, 12'd0, 3'd0);
    wait_end("trfc1", E_TRFC, I_AR1_TRFC, S_IDLE);
    see("mrs", I_MRS, S_IDLE, CMD_MRS, 2'd0, 12'h033, 3'd0);
    step;
    see("mrs_tmrd", I_MRS_TMRD, S_IDLE, CMD_NOP, 2'd0, 12'd0, 3'd0);
    wait_end("tmrd", E_TMRD, I_MRS_TMRD, S_IDLE);
    see("init_done", I_DONE, S_IDLE, CMD_NOP, 2'd0, 12'd0, 3'd0);
  endtask
  task automatic refresh;
    bus.sdram_ref_req = 1'b1;
    step;
    bus.sdram_ref_req = 1'b0;
    see("aref", I_DONE, S_AR, CMD_AREF, 2'd0, 12'd0, 3'b100);
    step;
    see("s_trfc", I_DONE, S_TRFC, CMD_NOP, 2'd0, 12'd0, 3'd0);
    wait_end("s_trfc", E_TRFC, I_DONE, S_TRFC);
    see("ref_idle", I_DONE, S_IDLE, CMD_NOP, 2'd0, 12'd0, 3'd0);
  endtask
  task automatic xfer(input bit wr, input logic [22:0] a, input bit abort);
    if (wr) begin
      bus.wr_addr = a;
      bus.rd_addr = 23'($urandom);
      bus.sdram_wr_req = 1'b1;
    end else begin
      bus.rd_addr = a;
      bus.wr_addr = 23'($urandom);
      bus.sdram_rd_req = 1'b1;
    end
    step;
    bus.sdram_wr_req = 1'b0;
    bus.sdram_rd_req = 1'b0;
    see("act", I_DONE, S_ACT, CMD_ACT, a[22:21], a[20:9], wr ? 3'b010 : 3'b001);
    step;
    see("trcd", I_DONE, S_TRCD, CMD_NOP, 2'd0, 12'd0, 3'd0);
    wait_end("trcd", E_TRCD, I_DONE, S_TRCD);
    see("rw_cmd", I_DONE, wr ? S_WR : S_RD, wr ? CMD_WR : CMD_RD, a[22:21], col_cmd_addr(a[8:0]), 3'd0);
    step;
    if (wr) begin
      see("wr_data", I_DONE, S_WR_DATA, CMD_NOP, 2'd0, 12'd0, 3'd0);
      if (abort) begin
        rst = 1'b1;
        step;
        rst = 1'b0;
        pi = I_POWON;
        pw = S_IDLE;
        see("abort", I_POWON, S_IDLE, CMD_NOP, 2'd0, 12'd0, 3'd0);
        return;
      end
      wait_end("twrite", E_TWRITE, I_DONE, S_WR_DATA);
      see("tdal", I_DONE, S_TDAL, CMD_NOP, 2'd0, 12'd0, 3'd0);
      wait_end("tdal", E_TDAL, I_DONE, S_TDAL);
    end else begin
      see("cl", I_DONE, S_CL, CMD_NOP, 2'd0, 12'd0, 3'd0);
      wait_end("tcl", E_TCL, I_DONE, S_CL);
      see("rd_data", I_DONE, S_RD_DATA, CMD_NOP, 2'd0, 12'd0, 3'd0);
      wait_end("tread", E_TREAD, I_DONE, S_RD_DATA);
      see("rwait", I_DONE, S_RWAIT, CMD_NOP, 2'd0, 12'd0, 3'd0);
      wait_end("twait", E_TWAIT, I_DONE, S_RWAIT);
    end
    see("xfer_idle", I_DONE, S_IDLE, CMD_NOP, 2'd0, 12'd0, 3'd0);
  endtask
  initial begin
    logic [22:0] a;
    bit wr;
    bus.sdram_ref_req = 1'b0;
    bus.sdram_wr_req = 1'b0;
    bus.sdram_rd_req = 1'b0;
    bus.wr_addr = '0;
    bus.rd_addr = '0;
    repeat (3) step;
    see("reset", I_POWON, S_IDLE, CMD_NOP, 2'd0, 12'd0, 3'd0);
    rst = 1'b0;
    // write request pending through init must stay unacknowledged until I_DONE
    bus.wr_addr = {2'd1, 12'h0A5, 9'h010};
    bus.sdram_wr_req = 1'b1;
    init_seq;
    xfer(1'b1, {2'd1, 12'h0A5, 9'h010}, 1'b0);
    xfer(1'b0, {2'd3, 12'hFFF, 9'h1FF}, 1'b0);
    a = 23'($urandom);
    bus.wr_addr = a;
    bus.sdram_wr_req = 1'b1;
    refresh;
    xfer(1'b1, a, 1'b0);
    a = 23'($urandom);
    bus.rd_addr = a;
    bus.sdram_rd_req = 1'b1;
    ref_domain = 1'b1;
    repeat (3) begin
      step;
      see("blocked", I_DONE, S_IDLE, CMD_NOP, 2'd0, 12'd0, 3'd0);
    end
    ref_domain = 1'b0;
    xfer(1'b0, a, 1'b0);
    for (int k = 0; k < 10; k++) begin
      a = 23'($urandom);
      if ($urandom_range(0, 2) == 0) refresh;
      else begin
        wr = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) begin
          ref_domain = 1'b1;
          bus.wr_addr = a;
          bus.rd_addr = a;
          bus.sdram_wr_req = wr;
          bus.sdram_rd_req = !wr;
          step;
          see("rnd_blocked", I_DONE, S_IDLE, CMD_NOP, 2'd0, 12'd0, 3'd0);
          ref_domain = 1'b0;
        end
        xfer(wr, a, 1'b0);
      end
    end
    xfer(1'b1, 23'($urandom), 1'b1);
    init_seq;
    xfer(1'b0, 23'($urandom), 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
